// File: rtl/mem_pkg.sv
// Shared load/store codes, controller state encoding and the alignment rule.
// Pure declarations; no timing or flow-control behaviour of its own.
package mem_pkg;

  localparam logic [2:0] LB  = 3'b001;
  localparam logic [2:0] LH  = 3'b010;
  localparam logic [2:0] LW  = 3'b011;
  localparam logic [2:0] LBU = 3'b101;
  localparam logic [2:0] LHU = 3'b110;

  localparam logic [1:0] SB = 2'b01;
  localparam logic [1:0] SH = 2'b10;
  localparam logic [1:0] SW = 2'b11;

  typedef enum logic [1:0] {IDLE, RD_ISSUE, RD_WAIT, WR} state_t;

  // Halfwords need an even address, words a multiple of four; bytes never fault.
  function automatic logic is_aligned(input logic [2:0] rd, input logic [1:0] wr,
                                      input logic [1:0] a);
    logic half;
    logic word;
    half = (rd == LH) || (rd == LHU) || (wr == SH);
    word = (rd == LW) || (wr == SW);
    return !(half && a[0]) && !(word && (a != 2'b00));
  endfunction

endpackage

// File: rtl/byte_merge.sv
// Splices store data into an old RAM word for sub-word stores.
// Purely combinational; no backpressure.
module byte_merge
  import mem_pkg::*;
(
  input  logic [31:0] old_word,
  input  logic [31:0] wdata,
  input  logic [1:0]  addr_lo,
  input  logic [1:0]  store_op,
  output logic [31:0] merged
);

  always_comb begin
    merged = old_word;
    case (store_op)
      SB: merged[{addr_lo, 3'b000} +: 8] = wdata[7:0];
      SH: begin
        if (addr_lo[1]) merged[31:16] = wdata[15:0];
        else            merged[15:0]  = wdata[15:0];
      end
      SW:      merged = wdata;
      default: merged = old_word;
    endcase
  end

endmodule

// File: rtl/dmem_ctrl.sv
// MEM-stage data-memory controller: loads, stores and sub-word read-modify-write.
// Load result 3 cycles after acceptance, sw write at +1, sb/sh write at +3; stalls while busy.
module dmem_ctrl
  import mem_pkg::*;
#(
  parameter int RAM_AW = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [2:0]        MemRead,
  input  logic [1:0]        MemWrite,
  input  logic [31:0]       Addr_out,
  input  logic [31:0]       wdata,
  output logic [RAM_AW-1:0] ram_addr,
  output logic              ram_we,
  output logic [31:0]       ram_wdata,
  input  logic [31:0]       ram_rdata,
  output logic [31:0]       rd_word,
  output logic [31:0]       rd_addr,
  output logic [2:0]        rd_op,
  output logic              rd_valid,
  output logic              stall,
  output logic              access_err
);

  state_t      state;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [2:0]  rop_q;
  logic [1:0]  wop_q;
  logic        we_q;
  logic [31:0] merged;
  logic        accept;
  logic        rd_illegal;
  logic        reject;

  assign req_ready  = (state == IDLE);
  assign stall      = ~req_ready;
  assign accept     = req_valid & req_ready;
  assign rd_illegal = !(MemRead inside {3'b000, LB, LH, LW, LBU, LHU});
  assign reject     = rd_illegal || ((MemRead != 3'b000) && (MemWrite != 2'b00)) ||
                      !is_aligned(MemRead, MemWrite, Addr_out[1:0]);

  // A reset arriving in the WR cycle must not let the strobe reach the RAM edge.
  assign ram_we = we_q & ~rst;

  byte_merge u_merge (
    .old_word (ram_rdata),
    .wdata    (wdata_q),
    .addr_lo  (addr_q[1:0]),
    .store_op (wop_q),
    .merged   (merged)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      addr_q     <= '0;
      wdata_q    <= '0;
      rop_q      <= '0;
      wop_q      <= '0;
      we_q       <= 1'b0;
      ram_addr   <= '0;
      ram_wdata  <= '0;
      rd_word    <= '0;
      rd_addr    <= '0;
      rd_op      <= '0;
      rd_valid   <= 1'b0;
      access_err <= 1'b0;
    end else begin
      we_q       <= 1'b0;
      rd_valid   <= 1'b0;
      access_err <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            addr_q   <= Addr_out;
            wdata_q  <= wdata;
            rop_q    <= MemRead;
            wop_q    <= MemWrite;
            ram_addr <= Addr_out[RAM_AW+1:2];
            if (reject) begin
              access_err <= 1'b1;
            end else if (MemRead != 3'b000) begin
              state <= RD_ISSUE;
            end else if (MemWrite == SW) begin
              ram_wdata <= wdata;
              we_q      <= 1'b1;
              state     <= WR;
            end else if (MemWrite != 2'b00) begin
              state <= RD_ISSUE;
            end
          end
        end
        RD_ISSUE: state <= RD_WAIT;
        RD_WAIT: begin
          if (wop_q == 2'b00) begin
            rd_word  <= ram_rdata;
            rd_addr  <= addr_q;
            rd_op    <= rop_q;
            rd_valid <= 1'b1;
            state    <= IDLE;
          end else begin
            ram_wdata <= merged;
            we_q      <= 1'b1;
            state     <= WR;
          end
        end
        WR:      state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_ctrl.sv
// Bench for dmem_ctrl: behavioural sync RAM, shadow memory model and a load scoreboard.
module tb_dmem_ctrl;
  import mem_pkg::*;

  localparam int AW = 10;

  logic          clk;
  logic          rst;
  logic          req_valid;
  logic          req_ready;
  logic [2:0]    MemRead;
  logic [1:0]    MemWrite;
  logic [31:0]   Addr_out;
  logic [31:0]   wdata;
  logic [AW-1:0] ram_addr;
  logic          ram_we;
  logic [31:0]   ram_wdata;
  logic [31:0]   ram_rdata;
  logic [31:0]   rd_word;
  logic [31:0]   rd_addr;
  logic [2:0]    rd_op;
  logic          rd_valid;
  logic          stall;
  logic          access_err;

  logic [31:0] bm_old, bm_wd, bm_out;
  logic [1:0]  bm_a, bm_op;

  dmem_ctrl #(.RAM_AW(AW)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .MemRead(MemRead), .MemWrite(MemWrite), .Addr_out(Addr_out), .wdata(wdata),
    .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
    .rd_word(rd_word), .rd_addr(rd_addr), .rd_op(rd_op), .rd_valid(rd_valid),
    .stall(stall), .access_err(access_err)
  );

  byte_merge u_bm (
    .old_word(bm_old), .wdata(bm_wd), .addr_lo(bm_a), .store_op(bm_op), .merged(bm_out)
  );

  typedef struct packed {
    logic [2:0]  rd;
    logic [1:0]  wr;
    logic [31:0] addr;
    logic [31:0] wd;
    logic        err;
  } vec_t;

  typedef struct {
    logic [31:0] word;
    logic [31:0] addr;
    logic [2:0]  op;
    int          cyc;
  } exp_t;

  int tests;
  int failed;
  int cyc;
  int we_cnt;
  int err_cnt;
  int stall_cnt;
  int last_we_cyc;
  logic mem_init;
  logic [31:0] mem     [0:(1<<AW)-1];
  logic [31:0] ref_mem [0:(1<<AW)-1];
  exp_t sbq[$];
  exp_t e;
  vec_t vecs[17];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not reach the summary");
    $fatal(1, "timeout");
  end

  function automatic logic [31:0] init_val(input int i);
    case (i)
      1:       return 32'h11223344;
      2:       return 32'hDEADBEEF;
      4:       return 32'h8899AABB;
      6:       return 32'h55667788;
      default: return 32'h13579BDF ^ (i * 32'h01000193);
    endcase
  endfunction

  function automatic logic [31:0] ref_merge(input logic [31:0] old, input logic [31:0] wd,
                                            input logic [1:0] a, input logic [1:0] op);
    logic [31:0] mask, dat;
    case (op)
      2'b01: begin
        mask = 32'h000000FF << {a, 3'b000};
        dat  = {24'b0, wd[7:0]} << {a, 3'b000};
      end
      2'b10: begin
        mask = a[1] ? 32'hFFFF0000 : 32'h0000FFFF;
        dat  = {wd[15:0], wd[15:0]};
      end
      2'b11: begin
        mask = 32'hFFFFFFFF;
        dat  = wd;
      end
      default: begin
        mask = 32'h0;
        dat  = 32'h0;
      end
    endcase
    return (old & ~mask) | (dat & mask);
  endfunction

  // Behavioural word RAM: one-cycle registered read, write on strobe.
  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < (1 << AW); i++) mem[i] <= init_val(i);
    end else if (ram_we) begin
      mem[ram_addr] <= ram_wdata;
    end
    ram_rdata <= mem[ram_addr];
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (ram_we) begin
      we_cnt++;
      last_we_cyc = cyc;
    end
    if (access_err) err_cnt++;
    if (stall) stall_cnt++;
    if (rd_valid) begin
      if (sbq.size() == 0) begin
        tests++;
        failed++;
        $display("FAIL rd_valid_unexpected: got rd_valid=1 with no load pending, expected 0");
      end else begin
        e = sbq.pop_front();
        check("rd_word", rd_word, e.word);
        check("rd_addr", rd_addr, e.addr);
        check("rd_op", {29'b0, rd_op}, {29'b0, e.op});
        check("rd_cycle", cyc, e.cyc);
      end
    end
  end

  task automatic wait_ready();
    int n = 0;
    while (!req_ready && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (!req_ready) begin
      tests++;
      failed++;
      $display("FAIL ready_timeout: req_ready=0 after %0d cycles, expected 1", n);
    end
  endtask

  task automatic run_vec(input int n, input vec_t v);
    int c0, we0, err0, st0;
    logic [AW-1:0] idx;
    logic is_ld, is_st;
    wait_ready();
    we0 = we_cnt; err0 = err_cnt; st0 = stall_cnt; c0 = cyc;
    idx = v.addr[AW+1:2];
    is_ld = !v.err && (v.rd != 3'b000);
    is_st = !v.err && (v.wr != 2'b00);
    req_valid = 1'b1; MemRead = v.rd; MemWrite = v.wr; Addr_out = v.addr; wdata = v.wd;
    if (is_ld) sbq.push_back('{ref_mem[idx], v.addr, v.rd, c0 + 3});
    if (is_st) ref_mem[idx] = ref_merge(ref_mem[idx], v.wd, v.addr[1:0], v.wr);
    @(posedge clk);
    #1;
    req_valid = 1'b0; MemRead = 3'b000; MemWrite = 2'b00;
    repeat (5) @(posedge clk);
    #1;
    check($sformatf("v%0d_err", n), err_cnt - err0, {31'b0, v.err});
    check($sformatf("v%0d_we_count", n), we_cnt - we0, {31'b0, is_st});
    if (is_st) begin
      check($sformatf("v%0d_we_cycle", n), last_we_cyc, c0 + ((v.wr == SW) ? 1 : 3));
      check($sformatf("v%0d_ram", n), mem[idx], ref_mem[idx]);
    end
    if (v.err || (v.rd == 3'b000 && v.wr == 2'b00))
      check($sformatf("v%0d_stall", n), stall_cnt - st0, 0);
  endtask

  initial begin
    int c0, we0;
    vecs[0]  = '{LW,     2'b00, 32'h00000010, 32'h00000000, 1'b0};
    vecs[1]  = '{3'b000, SB,    32'h00000006, 32'hFFFFFFAB, 1'b0};
    vecs[2]  = '{3'b000, SH,    32'h0000000A, 32'h00001234, 1'b0};
    vecs[3]  = '{LW,     2'b00, 32'h00000002, 32'h00000000, 1'b1};
    vecs[4]  = '{LH,     2'b00, 32'h00000003, 32'h00000000, 1'b1};
    vecs[5]  = '{LB,     SB,    32'h00000004, 32'h00000011, 1'b1};
    vecs[6]  = '{3'b100, 2'b00, 32'h00000000, 32'h00000000, 1'b1};
    vecs[7]  = '{3'b000, SW,    32'h0000000C, 32'h01020304, 1'b0};
    vecs[8]  = '{LB,     2'b00, 32'h0000000F, 32'h00000000, 1'b0};
    vecs[9]  = '{LHU,    2'b00, 32'h0000000E, 32'h00000000, 1'b0};
    vecs[10] = '{LBU,    2'b00, 32'h00000005, 32'h00000000, 1'b0};
    vecs[11] = '{3'b000, SH,    32'h00000001, 32'h0000BEEF, 1'b1};
    vecs[12] = '{3'b000, SW,    32'h00000022, 32'h12345678, 1'b1};
    vecs[13] = '{3'b000, 2'b00, 32'h00000040, 32'h00000000, 1'b0};
    vecs[14] = '{LW,     2'b00, 32'hFFFFF010, 32'h00000000, 1'b0};
    vecs[15] = '{3'b000, SB,    32'h00000013, 32'h0000005A, 1'b0};
    vecs[16] = '{LW,     2'b00, 32'h00000010, 32'h00000000, 1'b0};

    for (int i = 0; i < (1 << AW); i++) ref_mem[i] = init_val(i);
    rst = 1'b1; mem_init = 1'b1; req_valid = 1'b0;
    MemRead = 3'b000; MemWrite = 2'b00; Addr_out = 32'h0; wdata = 32'h0;
    bm_old = 32'h0; bm_wd = 32'h0; bm_a = 2'b00; bm_op = 2'b00;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0; mem_init = 1'b0;

    @(negedge clk);
    check("reset_req_ready", {31'b0, req_ready}, 1);
    check("reset_stall", {31'b0, stall}, 0);
    check("reset_ram_we", {31'b0, ram_we}, 0);
    check("reset_ram_addr", {22'b0, ram_addr}, 0);
    check("reset_rd_valid", {31'b0, rd_valid}, 0);
    check("reset_access_err", {31'b0, access_err}, 0);

    for (int op = 0; op < 4; op++) begin
      for (int a = 0; a < 4; a++) begin
        bm_old = $urandom; bm_wd = $urandom; bm_a = a[1:0]; bm_op = op[1:0];
        #1;
        check($sformatf("merge_op%0d_a%0d", op, a), bm_out, ref_merge(bm_old, bm_wd, bm_a, bm_op));
      end
    end

    @(posedge clk);
    #1;
    for (int i = 0; i < 17; i++) begin
      run_vec(i, vecs[i]);
      if (i == 1) check("sb_plan_word", mem[1], 32'h11AB3344);
      if (i == 2) check("sh_plan_word", mem[2], 32'h1234BEEF);
    end

    // Store then load at the same word, load held until the controller frees up.
    wait_ready();
    we0 = we_cnt; c0 = cyc;
    req_valid = 1'b1; MemRead = 3'b000; MemWrite = SW; Addr_out = 32'h20; wdata = 32'hCAFEF00D;
    ref_mem[8] = 32'hCAFEF00D;
    @(posedge clk);
    #1;
    check("b2b_stall_in_wr", {31'b0, stall}, 1);
    MemRead = LW; MemWrite = 2'b00; wdata = 32'h0;
    @(posedge clk);
    #1;
    check("b2b_ready_reenter", {31'b0, req_ready}, 1);
    sbq.push_back('{32'hCAFEF00D, 32'h00000020, LW, c0 + 5});
    @(posedge clk);
    #1;
    req_valid = 1'b0; MemRead = 3'b000;
    repeat (4) @(posedge clk);
    #1;
    check("b2b_we_count", we_cnt - we0, 1);
    check("b2b_we_cycle", last_we_cyc, c0 + 1);

    // Reset lands in the WR cycle of an sb: the write must be dropped.
    wait_ready();
    we0 = we_cnt; c0 = cyc;
    req_valid = 1'b1; MemWrite = SB; Addr_out = 32'h18; wdata = 32'h00000099;
    @(posedge clk);
    #1;
    req_valid = 1'b0; MemWrite = 2'b00;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    check("rst_wr_we_before", {31'b0, ram_we}, 1);
    rst = 1'b1;
    #1;
    check("rst_wr_we_forced", {31'b0, ram_we}, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("rst_wr_ram_kept", mem[6], 32'h55667788);
    check("rst_wr_we_count", we_cnt - we0, 0);
    check("rst_wr_req_ready", {31'b0, req_ready}, 1);
    check("rst_wr_stall", {31'b0, stall}, 0);
    check("rst_wr_ram_addr", {22'b0, ram_addr}, 0);
    check("rst_wr_ram_wdata", ram_wdata, 0);
    check("rst_wr_rd_word", rd_word, 0);
    check("rst_wr_rd_addr", rd_addr, 0);
    check("rst_wr_rd_op", {29'b0, rd_op}, 0);
    check("rst_wr_rd_valid", {31'b0, rd_valid}, 0);
    check("rst_wr_access_err", {31'b0, access_err}, 0);

    repeat (3) @(posedge clk);
    #1;
    check("scoreboard_drained", sbq.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
